// File: rtl/uart_pkg.sv
// Shared defaults and divisor arithmetic for the fractional UART baud generator.
// Holds the default oversample ratio and divisor widths, plus a helper that
// turns a clock frequency / baud rate pair into integer and fractional
// clocks-per-oversample-period.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DIV_W_DEF      = 16;
    localparam int FRAC_W_DEF     = 4;

    typedef struct packed {
        logic [31:0] int_part;
        logic [31:0] frac_part;
    } div_cfg_t;

    // Floor-divided integer part, and the fractional remainder expressed in
    // units of 2^-frac_w clocks.
    function automatic div_cfg_t calc_div(input longint clk_freq,
                                          input longint baud,
                                          input longint oversample,
                                          input longint frac_w);
        longint   den;
        longint   scaled;
        div_cfg_t r;
        den         = baud * oversample;
        scaled      = (clk_freq <<< frac_w) / den;
        r.int_part  = 32'(clk_freq / den);
        r.frac_part = 32'(scaled % (longint'(1) <<< frac_w));
        return r;
    endfunction

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator for the baud generator.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - synchronous clear of the accumulator to zero
//   step       - advance the accumulator by frac at a period boundary
//   frac       - fractional divisor currently in force
//   carry      - overflow of acc + frac; lengthens the current period by one clock
module uart_frac_accum
    import uart_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    // acc holds the phase at the start of the current period, so the carry
    // seen during the period is the one that decides its length.
    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator.
// Produces an oversample strobe whose period averages div_int + div_frac/2^FRAC_W
// clocks, and a bit strobe once every OVERSAMPLE oversample strobes.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   en                 - count enable; counters hold while low
//   restart            - synchronous realignment of all counters to zero
//   div_load           - capture div_int/div_frac (rejected when div_int < 2)
//   div_int, div_frac  - integer and fractional clocks per oversample period
//   os_tick            - one-cycle strobe in the last cycle of each period
//   baud_tick          - one-cycle strobe coincident with the os_phase wrap
//   os_phase           - index of the current oversample period within the bit
//   cfg_err            - one-cycle pulse when a load is rejected
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int DIV_W        = DIV_W_DEF,
    parameter int FRAC_W       = FRAC_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          restart,
    input  logic                          div_load,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    output logic                          os_tick,
    output logic                          baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          cfg_err
);

    localparam int                PH_W     = $clog2(OVERSAMPLE);
    localparam div_cfg_t          DEF_CFG  = calc_div(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE, FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_CFG.int_part[DIV_W-1:0];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_CFG.frac_part[FRAC_W-1:0];

    logic              rst_meta_p0;
    logic              rst_sync_p1;
    logic [DIV_W-1:0]  int_active;
    logic [DIV_W-1:0]  int_shadow;
    logic [FRAC_W-1:0] frac_active;
    logic [FRAC_W-1:0] frac_shadow;
    logic [DIV_W:0]    cyc_cnt;
    logic [DIV_W:0]    period_len;
    logic              carry;
    logic              period_end;
    logic              clear;
    logic              acc_step;
    logic              load_ok;
    logic              apply_div;

    // Reset release synchroniser stage: counters stay cleared until the
    // deasserted reset has passed through both flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_meta_p0 <= 1'b1;
            rst_sync_p1 <= rst_meta_p0;
        end
    end

    assign load_ok    = div_load && (div_int >= DIV_W'(2));
    assign clear      = !rst_sync_p1 || restart;
    // DIV_W+1 bits so int_active + carry cannot wrap at the maximum divisor.
    assign period_len = {1'b0, int_active} + {{DIV_W{1'b0}}, carry};
    // >= rather than == keeps the counter bounded if the divisor shrinks
    // while the counter is parked mid-period.
    assign period_end = (cyc_cnt + (DIV_W+1)'(1)) >= period_len;
    assign acc_step   = en && period_end && !clear;
    // The shadow is copied whenever it cannot disturb a running period.
    assign apply_div  = clear || !en || period_end;

    uart_frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .step  (acc_step),
        .frac  (frac_active),
        .carry (carry)
    );

    // Period counter, phase and strobe stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_active  <= DEF_INT;
            frac_active <= DEF_FRAC;
            int_shadow  <= DEF_INT;
            frac_shadow <= DEF_FRAC;
            cyc_cnt     <= '0;
            os_phase    <= '0;
            os_tick     <= 1'b0;
            baud_tick   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
            cfg_err   <= div_load && !load_ok;

            if (load_ok) begin
                int_shadow  <= div_int;
                frac_shadow <= div_frac;
            end

            // A load in the same cycle as the apply point bypasses the shadow
            // so the latest valid value always wins.
            if (apply_div) begin
                int_active  <= load_ok ? div_int  : int_shadow;
                frac_active <= load_ok ? div_frac : frac_shadow;
            end

            if (clear) begin
                cyc_cnt  <= '0;
                os_phase <= '0;
            end else if (en) begin
                if (period_end) begin
                    cyc_cnt   <= '0;
                    os_tick   <= 1'b1;
                    os_phase  <= os_phase + PH_W'(1);
                    baud_tick <= (os_phase == PH_W'(OVERSAMPLE - 1));
                end else begin
                    cyc_cnt <= cyc_cnt + (DIV_W+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
module tb_uart_baud_gen_frac;

    localparam int CLK_FREQ     = 50000000;
    localparam int DEFAULT_BAUD = 9600;
    localparam int OVERSAMPLE   = 16;
    localparam int DIV_W        = 16;
    localparam int FRAC_W       = 4;
    localparam int FSCALE       = 1 << FRAC_W;
    localparam int DEF_INT      = CLK_FREQ / (DEFAULT_BAUD * OVERSAMPLE);
    localparam int DEF_FRAC     = int'((longint'(CLK_FREQ) * FSCALE / (DEFAULT_BAUD * OVERSAMPLE)) % FSCALE);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              restart;
    logic              div_load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick;
    logic              baud_tick;
    logic [3:0]        os_phase;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: clocks left in the current period, phase within the bit,
    // fractional phase, active and shadow divisor.
    int m_rem, m_acc, m_phase, m_int, m_frac, m_sint, m_sfrac;
    bit m_valid = 1'b0;

    uart_baud_gen_frac #(
        .CLK_FREQ     (CLK_FREQ),
        .DEFAULT_BAUD (DEFAULT_BAUD),
        .OVERSAMPLE   (OVERSAMPLE),
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .restart   (restart),
        .div_load  (div_load),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .os_tick   (os_tick),
        .baud_tick (baud_tick),
        .os_phase  (os_phase),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Close a period: fold the fraction in, adopt the shadow divisor and size
    // the next period as int + carry out of acc + frac.
    task automatic model_period_end();
        m_acc  = (m_acc + m_frac) % FSCALE;
        m_int  = m_sint;
        m_frac = m_sfrac;
        m_rem  = m_int + (m_acc + m_frac) / FSCALE;
    endtask

    task automatic step(input bit e, input bit rs, input bit ld, input int di, input int df);
        bit ld_ok;
        bit exp_os;
        bit exp_baud;
        en       = e;
        restart  = rs;
        div_load = ld;
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        @(posedge clk);
        #1;
        cyc++;
        ld_ok    = ld && (di >= 2);
        exp_os   = 1'b0;
        exp_baud = 1'b0;
        if (ld_ok) begin
            m_sint  = di;
            m_sfrac = df;
        end
        if (rs) begin
            m_acc   = 0;
            m_phase = 0;
            m_int   = m_sint;
            m_frac  = m_sfrac;
            m_rem   = m_int + (m_acc + m_frac) / FSCALE;
        end else if (e) begin
            m_rem--;
            if (m_rem == 0) begin
                exp_os   = 1'b1;
                exp_baud = (m_phase == OVERSAMPLE - 1);
                m_phase  = (m_phase + 1) % OVERSAMPLE;
                model_period_end();
            end
        end else begin
            m_int  = m_sint;
            m_frac = m_sfrac;
        end
        if (m_valid) begin
            chk("os_tick", os_tick, exp_os);
            chk("baud_tick", baud_tick, exp_baud);
            chk("os_phase", os_phase, m_phase);
            chk("cfg_err", cfg_err, ld && (di < 2));
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1, 0, 0, 0, 0);
            n++;
        end while (os_tick !== 1'b1 && n < 4000);
    endtask

    task automatic release_and_sync(input string tag);
        int waited;
        bit seen;
        m_valid  = 1'b0;
        en       = 1'b1;
        restart  = 1'b0;
        div_load = 1'b0;
        rst_n    = 1'b1;
        waited   = 0;
        seen     = 1'b0;
        while (!seen && waited < DEF_INT + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            waited++;
            if (os_tick === 1'b1) seen = 1'b1;
        end
        chk({tag, "_first_tick_seen"}, seen, 1);
        chk({tag, "_first_tick_window"}, (waited >= DEF_INT) && (waited <= DEF_INT + 4), 1);
        chk({tag, "_first_phase"}, os_phase, 1);
        chk({tag, "_first_baud"}, baud_tick, 0);
        m_sint  = DEF_INT;
        m_sfrac = DEF_FRAC;
        m_int   = DEF_INT;
        m_frac  = DEF_FRAC;
        m_acc   = 0;
        m_phase = 1;
        model_period_end();
        m_valid = 1'b1;
    endtask

    task automatic run_bits(input string tag, input int exp_spacing);
        int first;
        int second;
        int n;
        first  = -1;
        second = -1;
        n      = 0;
        while (second < 0 && n < 3 * exp_spacing + 100) begin
            step(1, 0, 0, 0, 0);
            n++;
            if (baud_tick === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        chk({tag, "_baud_spacing"}, second - first, exp_spacing);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int k;
        int guard;
        rst_n    = 1'b1;
        en       = 1'b0;
        restart  = 1'b0;
        div_load = 1'b0;
        div_int  = '0;
        div_frac = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_os_tick", os_tick, 0);
        chk("rst_baud_tick", baud_tick, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_os_phase", os_phase, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_os_tick", os_tick, 0);
        chk("rst_hold_os_phase", os_phase, 0);

        // Power-on defaults: 325.5 clocks per os period, 5208 clocks per bit.
        release_and_sync("por");
        chk("def_int_value", DEF_INT, 325);
        chk("def_frac_value", DEF_FRAC, 8);
        run_bits("def", 5208);

        // Rejected loads leave the divisor alone.
        step(1, 0, 1, 1, 5);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 700; i++) step(1, 0, 0, 0, 0);

        // Restart with 4 + 8/16: periods 4,5,4,5 from acc = 0.
        step(1, 1, 1, 4, 8);
        chk("frac_restart_phase", os_phase, 0);
        wait_tick(n); chk("frac_p0", n, 4);
        wait_tick(n); chk("frac_p1", n, 5);
        wait_tick(n); chk("frac_p2", n, 4);
        wait_tick(n); chk("frac_p3", n, 5);
        run_bits("frac", 72);

        // Zero divisor rejected; two loads in one period, the last one wins.
        step(1, 0, 1, 0, 3);
        step(1, 0, 1, 9, 0);
        step(1, 0, 1, 7, 0);
        wait_tick(n);
        wait_tick(n); chk("shadow_new_p0", n, 7);
        wait_tick(n); chk("shadow_new_p1", n, 7);

        // Enable dropped for 10 clocks while os_phase is 7.
        guard = 0;
        while (os_phase !== 4'd7 && guard < 200) begin
            step(1, 0, 0, 0, 0);
            guard++;
        end
        chk("en_reach_phase7", os_phase, 7);
        k = 3;
        for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        wait_tick(n);
        chk("en_resume_total", n + k, 7);

        // Restart and load 6/0 together; restart also beats en = 0.
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 6, 0);
        chk("rs_load_phase", os_phase, 0);
        wait_tick(n); chk("rs_load_first", n, 6);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("rs_prio_phase", os_phase, 0);
        wait_tick(n); chk("rs_prio_first", n, 6);

        // Reset mid-bit with a shadow load pending.
        wait_tick(n);
        wait_tick(n);
        step(1, 0, 1, 9, 0);
        m_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_os_tick", os_tick, 0);
        chk("midrst_baud_tick", baud_tick, 0);
        chk("midrst_cfg_err", cfg_err, 0);
        chk("midrst_os_phase", os_phase, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        release_and_sync("rst2");
        run_bits("rst2", 5208);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
